object_centroid: RTL

Upstream stage of the object-overlay colouring block. It computes the centroid (x_obj, y_obj) of all pixels flagged as object in one video frame. During the frame it accumulates the coordinate sums and the pixel count. At frame end it divides each sum by the count with one shared serial divider. It then holds the result steady for the whole next frame so the overlay stage can compare every VGA position against it.

---
 rtl/centroid_pkg.sv | 16 +
 rtl/object_centroid_serial_divider.sv | 84 ++++++++
 rtl/object_centroid.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/centroid_pkg.sv
// Shared types and default widths for the object centroid block.
package centroid_pkg;

    localparam int unsigned DEF_DISP_WIDTH  = 11;
    localparam int unsigned DEF_COUNT_WIDTH = 2 * DEF_DISP_WIDTH;
    localparam int unsigned DEF_SUM_WIDTH   = 3 * DEF_DISP_WIDTH;
    localparam int unsigned DEF_MIN_PIXELS  = 16;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIV_X  = 2'd1,
        DIV_Y  = 2'd2,
        UPDATE = 2'd3
    } centroid_state_e;

endpackage

// File: rtl/object_centroid_serial_divider.sv
// Restoring serial divider: one quotient bit per cycle. The first bit is
// resolved on the start edge, so done pulses DIVIDEND_WIDTH cycles after start.
module serial_divider #(
    parameter int unsigned DIVIDEND_WIDTH = 33,
    parameter int unsigned DIVISOR_WIDTH  = 22
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic                      done,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_WIDTH + 1);

    logic [DIVISOR_WIDTH-1:0]  rem_q;
    logic [DIVIDEND_WIDTH-1:0] dq_q;
    logic [DIVISOR_WIDTH-1:0]  dvs_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      busy_q;
    logic                      done_q;

    logic [DIVISOR_WIDTH-1:0]  rem_src;
    logic [DIVIDEND_WIDTH-1:0] dq_src;
    logic [DIVISOR_WIDTH-1:0]  dvs_src;
    logic [DIVISOR_WIDTH:0]    rem_shift;
    logic                      bit_c;
    logic [DIVISOR_WIDTH-1:0]  rem_next;
    logic [DIVIDEND_WIDTH-1:0] dq_next;

    // One restoring step, fed from the ports on start and from the registers otherwise.
    always_comb begin
        rem_src = rem_q;
        dq_src  = dq_q;
        dvs_src = dvs_q;
        if (start) begin
            rem_src = '0;
            dq_src  = dividend;
            dvs_src = divisor;
        end
        rem_shift = {rem_src, dq_src[DIVIDEND_WIDTH-1]};
        bit_c     = (rem_shift >= {1'b0, dvs_src});
        rem_next  = bit_c ? DIVISOR_WIDTH'(rem_shift - {1'b0, dvs_src})
                          : rem_shift[DIVISOR_WIDTH-1:0];
        dq_next   = {dq_src[DIVIDEND_WIDTH-2:0], bit_c};
    end

    // Iteration registers, bit counter and done pulse.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rem_q  <= '0;
            dq_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_next;
                dq_q   <= dq_next;
                dvs_q  <= divisor;
                cnt_q  <= CNT_W'(DIVIDEND_WIDTH - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_next;
                dq_q  <= dq_next;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient = dq_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: rtl/object_centroid.sv
// Per-frame centroid of object pixels: accumulate during the frame, divide
// once at frame end with a shared serial divider, hold the result a frame.
module object_centroid
    import centroid_pkg::*;
#(
    parameter int unsigned DISP_WIDTH  = DEF_DISP_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int unsigned SUM_WIDTH   = DEF_SUM_WIDTH,
    parameter int unsigned MIN_PIXELS  = DEF_MIN_PIXELS
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic                  pixel_valid,
    input  logic                  is_obj,
    input  logic [DISP_WIDTH-1:0] x_pos,
    input  logic [DISP_WIDTH-1:0] y_pos,
    input  logic                  frame_end,
    output logic [DISP_WIDTH-1:0] x_obj,
    output logic [DISP_WIDTH-1:0] y_obj,
    output logic                  obj_found,
    output logic                  obj_valid,
    output logic                  busy
);

    centroid_state_e state_q, state_d;

    logic [SUM_WIDTH-1:0]   sum_x_q, sum_y_q, sum_x_c, sum_y_c;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_c;
    logic [SUM_WIDTH-1:0]   snap_sum_x_q, snap_sum_y_q;
    logic [COUNT_WIDTH-1:0] snap_cnt_q;
    logic                   pix_c, fe_accept_c, go_c;

    logic                   div_start_q, div_start_c;
    logic [SUM_WIDTH-1:0]   div_dividend_c, div_quotient;
    logic                   div_done, div_busy, div_fin_c;
    logic [DISP_WIDTH-1:0]  q_sat_c, q_x_q, q_y_q;

    // Live accumulator update including the current pixel; threshold decision on that total.
    always_comb begin
        pix_c   = enable & pixel_valid & is_obj;
        sum_x_c = sum_x_q;
        sum_y_c = sum_y_q;
        cnt_c   = cnt_q;
        if (pix_c) begin
            sum_x_c = sum_x_q + SUM_WIDTH'(x_pos);
            sum_y_c = sum_y_q + SUM_WIDTH'(y_pos);
            if (cnt_q != '1) begin
                cnt_c = cnt_q + COUNT_WIDTH'(1);
            end
        end
        fe_accept_c = frame_end && (state_q == ACCUM);
        go_c        = (cnt_c >= COUNT_WIDTH'(MIN_PIXELS)) && (cnt_c != '0);
        div_fin_c   = div_done && !div_busy;
        // A mean always fits; the clamp only guards the narrowing.
        q_sat_c     = (|div_quotient[SUM_WIDTH-1:DISP_WIDTH]) ? '1
                                                              : div_quotient[DISP_WIDTH-1:0];
    end

    // Next-state and divider control.
    always_comb begin
        state_d        = state_q;
        div_start_c    = div_start_q;
        div_dividend_c = snap_sum_x_q;
        case (state_q)
            ACCUM: begin
                if (fe_accept_c && go_c) begin
                    state_d = DIV_X;
                end
            end
            DIV_X: begin
                if (div_fin_c) begin
                    state_d        = DIV_Y;
                    div_start_c    = 1'b1;
                    div_dividend_c = snap_sum_y_q;
                end
            end
            DIV_Y: begin
                if (div_fin_c) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Live accumulators; every frame_end restarts them empty.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
        end else if (frame_end) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
        end else begin
            sum_x_q <= sum_x_c;
            sum_y_q <= sum_y_c;
            cnt_q   <= cnt_c;
        end
    end

    // Snapshot of the finished frame and deferred start for the X division.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            snap_sum_x_q <= '0;
            snap_sum_y_q <= '0;
            snap_cnt_q   <= '0;
            div_start_q  <= 1'b0;
        end else begin
            div_start_q <= fe_accept_c && go_c;
            if (fe_accept_c) begin
                snap_sum_x_q <= sum_x_c;
                snap_sum_y_q <= sum_y_c;
                snap_cnt_q   <= cnt_c;
            end
        end
    end

    // Quotient capture for each axis.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            q_x_q <= '0;
            q_y_q <= '0;
        end else if (div_fin_c) begin
            if (state_q == DIV_X) begin
                q_x_q <= q_sat_c;
            end
            if (state_q == DIV_Y) begin
                q_y_q <= q_sat_c;
            end
        end
    end

    // Published outputs: the pair changes together, only when leaving UPDATE.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            x_obj     <= '0;
            y_obj     <= '0;
            obj_found <= 1'b0;
            obj_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            obj_valid <= 1'b0;
            busy      <= (state_d != ACCUM);
            if (state_q == UPDATE) begin
                x_obj     <= q_x_q;
                y_obj     <= q_y_q;
                obj_found <= 1'b1;
                obj_valid <= 1'b1;
            end else if (fe_accept_c && !go_c) begin
                obj_found <= 1'b0;
            end
        end
    end

    serial_divider #(
        .DIVIDEND_WIDTH (SUM_WIDTH),
        .DIVISOR_WIDTH  (COUNT_WIDTH)
    ) u_div (
        .clk      (clk),
        .aresetn  (aresetn),
        .start    (div_start_c),
        .dividend (div_dividend_c),
        .divisor  (snap_cnt_q),
        .quotient (div_quotient),
        .done     (div_done),
        .busy     (div_busy)
    );

endmodule
